// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO width-conversion stages (unpacker now,
// matching packer later): slice ratio, index width and the hold-state encoding.
package fifo_pkg;

  // Two-state holding FSM: nothing held, or one FIFO word being sliced out.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } unpack_state_e;

  // Number of narrow slices carried by one wide word.
  function automatic int slice_ratio(input int in_width, input int out_width);
    return in_width / out_width;
  endfunction

  // Width of a slice index; never narrower than one bit so the index register
  // stays well formed even for degenerate ratios.
  function automatic int idx_width(input int ratio);
    int w;
    if (ratio > 1) begin
      w = $clog2(ratio);
    end else begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_unpacker.sv
// Pops IN_WIDTH words from a show-ahead FIFO and emits them as RATIO narrower
// slices on a valid/ready stream, one slice per cycle with no bubble between
// words. The pop for the next word is issued in the same cycle the last slice
// of the current word is accepted, so the stream stays continuous.
module fifo_unpacker
  import fifo_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 2,
  parameter int MSB_FIRST = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  fifo_dout,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic                 flush,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic                 busy
);

  localparam int RATIO = slice_ratio(IN_WIDTH, OUT_WIDTH);
  localparam int IDX_W = idx_width(RATIO);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

  // Reject width combinations that cannot be sliced evenly.
  if (((IN_WIDTH % OUT_WIDTH) != 0) || (RATIO < 2)) begin : g_param_check
    $fatal(1, "fifo_unpacker: IN_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
  end

  unpack_state_e          state_r;
  unpack_state_e          state_next_s;
  logic [IN_WIDTH-1:0]    sreg_r;
  logic [IDX_W-1:0]       idx_r;
  logic [CNT_WIDTH-1:0]   word_cnt_r;
  logic                   held_s;
  logic                   at_last_s;
  logic                   xfer_s;
  logic                   last_xfer_s;
  logic                   rd_en_s;
  logic [OUT_WIDTH-1:0]   m_data_s;

  assign held_s      = (state_r == ST_HOLD);
  assign at_last_s   = (idx_r == IDX_LAST);
  assign xfer_s      = held_s && m_ready;
  assign last_xfer_s = xfer_s && at_last_s;

  // Pop request: only when a word can be taken this edge, never during flush
  // or reset, and never against an empty FIFO.
  always_comb begin
    rd_en_s = 1'b0;
    if (rst_n && !flush && !fifo_empty && (!held_s || last_xfer_s)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Hold-state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next hold state: flush wins, otherwise load on pop and release after the
  // last slice when no follow-on word is available.
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (rd_en_s) begin
            state_next_s = ST_HOLD;
          end else begin
            state_next_s = ST_EMPTY;
          end
        end
        ST_HOLD: begin
          if (last_xfer_s && !rd_en_s) begin
            state_next_s = ST_EMPTY;
          end else begin
            state_next_s = ST_HOLD;
          end
        end
        default: begin
          state_next_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Shift register and slice index: capture on pop, advance on non-last accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_r <= '0;
      idx_r  <= '0;
    end else if (flush) begin
      sreg_r <= sreg_r;
      idx_r  <= '0;
    end else if (rd_en_s) begin
      sreg_r <= fifo_dout;
      idx_r  <= '0;
    end else if (xfer_s && !at_last_s) begin
      sreg_r <= sreg_r;
      idx_r  <= idx_r + IDX_W'(1);
    end else begin
      sreg_r <= sreg_r;
      idx_r  <= idx_r;
    end
  end

  // Completed-word counter; a last slice accepted under flush is discarded
  // and therefore not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_r <= '0;
    end else if (!flush && last_xfer_s) begin
      word_cnt_r <= word_cnt_r + CNT_WIDTH'(1);
    end else begin
      word_cnt_r <= word_cnt_r;
    end
  end

  // Slice select from the held word; depends only on registers so m_ready
  // has no combinational path to the data.
  always_comb begin
    m_data_s = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (idx_r == IDX_W'(i)) begin
        if (MSB_FIRST != 0) begin
          m_data_s = sreg_r[IN_WIDTH-1-i*OUT_WIDTH -: OUT_WIDTH];
        end else begin
          m_data_s = sreg_r[i*OUT_WIDTH +: OUT_WIDTH];
        end
      end else begin
        m_data_s = m_data_s;
      end
    end
  end

  // Stream outputs are all derived from the hold state and datapath registers.
  always_comb begin
    m_valid = held_s;
    busy    = held_s;
    m_last  = held_s && at_last_s;
    m_data  = m_data_s;
  end

  assign fifo_rd_en = rd_en_s;
  assign word_cnt   = word_cnt_r;

endmodule

// File: tb/tb_fifo_unpacker.sv
// Directed bench for fifo_unpacker: a table of per-cycle stimulus/expectation
// rows on an MSB-first instance, plus a hand sequence on an LSB-first instance
// with a 4-bit counter to exercise wrap-around.
module tb_fifo_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        m_ready;

  // Instance A: defaults, MSB first.
  logic [7:0]  a_dout;
  logic        a_empty;
  logic        a_rd;
  logic [1:0]  a_data;
  logic        a_valid;
  logic        a_last;
  logic [15:0] a_cnt;
  logic        a_busy;

  // Instance B: LSB first, 4-bit counter.
  logic [7:0]  b_dout;
  logic        b_empty;
  logic        b_rd;
  logic [1:0]  b_data;
  logic        b_valid;
  logic        b_last;
  logic [3:0]  b_cnt;
  logic        b_busy;

  // Show-ahead FIFO models.
  logic [7:0]  mem_a [0:63];
  logic [7:0]  mem_b [0:63];
  logic [6:0]  a_wp = 7'd0;
  logic [6:0]  a_rp;
  logic [6:0]  b_wp = 7'd0;
  logic [6:0]  b_rp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign a_empty = (a_rp == a_wp);
  assign a_dout  = mem_a[a_rp[5:0]];
  assign b_empty = (b_rp == b_wp);
  assign b_dout  = mem_b[b_rp[5:0]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rp <= 7'd0;
      b_rp <= 7'd0;
    end else begin
      if (a_rd) a_rp <= a_rp + 7'd1;
      if (b_rd) b_rp <= b_rp + 7'd1;
    end
  end

  fifo_unpacker #(.IN_WIDTH(8), .OUT_WIDTH(2), .MSB_FIRST(1), .CNT_WIDTH(16)) u_a (
    .clk(clk), .rst_n(rst_n), .fifo_dout(a_dout), .fifo_empty(a_empty),
    .fifo_rd_en(a_rd), .flush(flush), .m_data(a_data), .m_valid(a_valid),
    .m_ready(m_ready), .m_last(a_last), .word_cnt(a_cnt), .busy(a_busy)
  );

  fifo_unpacker #(.IN_WIDTH(8), .OUT_WIDTH(2), .MSB_FIRST(0), .CNT_WIDTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .fifo_dout(b_dout), .fifo_empty(b_empty),
    .fifo_rd_en(b_rd), .flush(flush), .m_data(b_data), .m_valid(b_valid),
    .m_ready(m_ready), .m_last(b_last), .word_cnt(b_cnt), .busy(b_busy)
  );

  typedef struct packed {
    logic        push;
    logic [7:0]  pval;
    logic        rdy;
    logic        fl;
    logic        ev;
    logic [1:0]  ed;
    logic        el;
    logic        er;
    logic [15:0] ec;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic push, input logic [7:0] pval, input logic rdy,
                     input logic fl, input logic ev, input logic [1:0] ed,
                     input logic el, input logic er, input logic [15:0] ec);
    vec_t v;
    v.push = push; v.pval = pval; v.rdy = rdy; v.fl = fl;
    v.ev = ev; v.ed = ed; v.el = el; v.er = er; v.ec = ec;
    vq.push_back(v);
  endtask

  task automatic push_a(input logic [7:0] v);
    mem_a[a_wp[5:0]] = v;
    a_wp = a_wp + 7'd1;
  endtask

  task automatic push_b(input logic [7:0] v);
    mem_b[b_wp[5:0]] = v;
    b_wp = b_wp + 7'd1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [1:0] lsb_exp [0:3];
    lsb_exp[0] = 2'd0; lsb_exp[1] = 2'd1; lsb_exp[2] = 2'd3; lsb_exp[3] = 2'd2;

    // Rows: push, pval, rdy, flush, exp valid, exp data, exp last, exp rd_en, exp cnt
    // Single word 0xB4 -> 2,3,1,0 then empty.
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 16'd0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 16'd0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 16'd0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 16'd0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd1);
    // Back-to-back 0xB4, 0x1E.
    add(1'b1, 8'hB4, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 16'd1);
    add(1'b1, 8'h1E, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 16'd1);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 16'd1);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 16'd1);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 16'd1);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 16'd2);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 16'd2);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 16'd2);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 16'd2);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd3);
    // Backpressure on 0xB4 with 0x1E queued behind it.
    add(1'b1, 8'hB4, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 16'd3);
    add(1'b1, 8'h1E, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 16'd3);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 16'd3);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 16'd3);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 16'd3);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 16'd3);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 16'd3);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 16'd3);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 16'd3);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 16'd3);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 16'd3);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 16'd4);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 16'd4);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 16'd4);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 16'd4);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd5);
    // Flush after two slices of 0xB4 with 0x1E queued.
    add(1'b1, 8'hB4, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 16'd5);
    add(1'b1, 8'h1E, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 16'd5);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 16'd5);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 16'd5);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 16'd5);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 16'd5);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 16'd5);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 16'd5);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 16'd5);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd6);
    // Flush coinciding with an accepted last slice: word is not counted.
    add(1'b1, 8'hB4, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 16'd6);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 16'd6);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 16'd6);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 16'd6);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 16'd6);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd6);

    // Reset with a word already waiting in FIFO A.
    rst_n   = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;
    push_a(8'hB4);
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, a_valid}, 32'd0);
    chk("rst_rd_en", {31'd0, a_rd}, 32'd0);
    chk("rst_cnt",   {16'd0, a_cnt}, 32'd0);
    chk("rst_last",  {31'd0, a_last}, 32'd0);
    chk("rst_data",  {30'd0, a_data}, 32'd0);
    chk("rst_busy",  {31'd0, a_busy}, 32'd0);
    chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_rd_en", {31'd0, a_rd}, 32'd1);
    chk("rel_valid", {31'd0, a_valid}, 32'd0);

    // Table-driven section on instance A.
    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1;
      m_ready = vq[i].rdy;
      flush   = vq[i].fl;
      if (vq[i].push) push_a(vq[i].pval);
      @(negedge clk);
      chk($sformatf("row%0d_valid", i), {31'd0, a_valid}, {31'd0, vq[i].ev});
      chk($sformatf("row%0d_busy", i),  {31'd0, a_busy},  {31'd0, vq[i].ev});
      chk($sformatf("row%0d_last", i),  {31'd0, a_last},  {31'd0, vq[i].el});
      chk($sformatf("row%0d_rd_en", i), {31'd0, a_rd},    {31'd0, vq[i].er});
      chk($sformatf("row%0d_cnt", i),   {16'd0, a_cnt},   {16'd0, vq[i].ec});
      if (vq[i].ev) begin
        chk($sformatf("row%0d_data", i), {30'd0, a_data}, {30'd0, vq[i].ed});
      end
    end

    // Instance B: 16 words of 0xB4, LSB first, counter wraps 15 -> 0.
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    flush   = 1'b0;
    for (int w = 0; w < 16; w++) push_b(8'hB4);
    @(negedge clk);
    chk("b_first_rd_en", {31'd0, b_rd}, 32'd1);
    chk("b_first_valid", {31'd0, b_valid}, 32'd0);
    chk("b_first_cnt",   {28'd0, b_cnt}, 32'd0);
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk($sformatf("b%0d_valid", i), {31'd0, b_valid}, 32'd1);
      chk($sformatf("b%0d_data", i),  {30'd0, b_data}, {30'd0, lsb_exp[i % 4]});
      chk($sformatf("b%0d_last", i),  {31'd0, b_last}, ((i % 4) == 3) ? 32'd1 : 32'd0);
      chk($sformatf("b%0d_cnt", i),   {28'd0, b_cnt}, 32'(i / 4));
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("b_wrap_cnt",   {28'd0, b_cnt}, 32'd0);
    chk("b_end_valid",  {31'd0, b_valid}, 32'd0);
    chk("b_end_rd_en",  {31'd0, b_rd}, 32'd0);
    chk("a_idle_cnt",   {16'd0, a_cnt}, 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
